// File: rtl/ps2_joypad_pkg.sv
// rtl/ps2_joypad_pkg.sv - Scancode map, joypad bit indices and read FSM states.
package ps2_joypad_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_SEMI  = 8'h4C;
  localparam logic [7:0] SC_QUOTE = 8'h52;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int KEY_DOWN   = 7;
  localparam int KEY_UP     = 6;
  localparam int KEY_LEFT   = 5;
  localparam int KEY_RIGHT  = 4;
  localparam int KEY_START  = 3;
  localparam int KEY_SELECT = 2;
  localparam int KEY_A      = 1;
  localparam int KEY_B      = 0;

  // Held flags: [7:0] primary keys in joypad order, [11:8] arrow keys for bits 7..4.
  localparam int NUM_FLAGS  = 12;
  localparam int ARROW_OFS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_GAP
  } rd_state_e;

  function automatic logic is_ignored(input logic [7:0] code);
    case (code)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_FLAGS-1:0] flag_mask(input logic [7:0] code, input logic ext);
    logic [NUM_FLAGS-1:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_W:     m[KEY_UP]     = 1'b1;
        SC_S:     m[KEY_DOWN]   = 1'b1;
        SC_A:     m[KEY_LEFT]   = 1'b1;
        SC_D:     m[KEY_RIGHT]  = 1'b1;
        SC_ENTER: m[KEY_START]  = 1'b1;
        SC_SPACE: m[KEY_SELECT] = 1'b1;
        SC_SEMI:  m[KEY_A]      = 1'b1;
        SC_QUOTE: m[KEY_B]      = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    m[KEY_UP + ARROW_OFS]    = 1'b1;
        SC_DOWN:  m[KEY_DOWN + ARROW_OFS]  = 1'b1;
        SC_LEFT:  m[KEY_LEFT + ARROW_OFS]  = 1'b1;
        SC_RIGHT: m[KEY_RIGHT + ARROW_OFS] = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - Two-flop synchronizer with a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ps2_joypad_decoder.sv
// rtl/ps2_joypad_decoder.sv - PS/2 scancode FIFO reader and joypad decoder with UART override.
module ps2_joypad_decoder
  import ps2_joypad_pkg::*;
(
  input  logic        clk_4,
  input  logic        vb_rst,
  input  logic        ps2_ready,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_overflow,
  output logic        ps2_rdn,
  output logic        ps2_clrn,
  input  logic        src_uart,
  input  logic        uart_rdy,
  input  logic [7:0]  uart_data,
  output logic [7:0]  key,
  output logic [15:0] last_codes
);

  rd_state_e            state_q, state_d;
  logic [7:0]           cap_q, cap_d;
  logic                 cap_vld_q, cap_vld_d;
  logic                 clr_q, clr_d;
  logic                 ext_q, ext_d;
  logic                 brk_q, brk_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d, mask;
  logic [15:0]          last_q, last_d;
  logic [7:0]           uart_key_q, uart_key_d;
  logic [7:0]           key_q, key_d;
  logic [7:0]           ps2_vec;
  logic                 uart_rise;

  sync_edge u_uart_sync (
    .clk  (clk_4),
    .rst  (vb_rst),
    .din  (uart_rdy),
    .rise (uart_rise)
  );

  // Clear pulse is suppressed on the cycle after itself: the FIFO drops overflow one edge late.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    cap_vld_d = 1'b0;
    clr_d     = 1'b0;
    if (ps2_overflow) begin
      clr_d   = ~clr_q;
      state_d = ST_GAP;
    end else begin
      case (state_q)
        ST_IDLE: if (ps2_ready) state_d = ST_READ;
        ST_READ: begin
          cap_d     = ps2_data;
          cap_vld_d = 1'b1;
          state_d   = ST_GAP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    flags_d = flags_q;
    last_d  = last_q;
    mask    = '0;
    if (clr_q) begin
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      flags_d = '0;
      last_d  = '0;
    end else if (cap_vld_q) begin
      last_d = {last_q[7:0], cap_q};
      if (cap_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (cap_q == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        mask    = is_ignored(cap_q) ? '0 : flag_mask(cap_q, ext_q);
        flags_d = brk_q ? (flags_q & ~mask) : (flags_q | mask);
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end
    end
  end

  assign ps2_vec = flags_q[7:0] | {flags_q[NUM_FLAGS-1:8], 4'b0000};

  always_comb begin
    uart_key_d = (uart_rise && src_uart) ? uart_data : uart_key_q;
    key_d      = src_uart ? uart_key_q : ps2_vec;
  end

  always_ff @(posedge clk_4 or posedge vb_rst) begin
    if (vb_rst) begin
      state_q    <= ST_IDLE;
      cap_q      <= '0;
      cap_vld_q  <= 1'b0;
      clr_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      flags_q    <= '0;
      last_q     <= '0;
      uart_key_q <= '0;
      key_q      <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      cap_vld_q  <= cap_vld_d;
      clr_q      <= clr_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      flags_q    <= flags_d;
      last_q     <= last_d;
      uart_key_q <= uart_key_d;
      key_q      <= key_d;
    end
  end

  assign ps2_rdn    = ~((state_q == ST_READ) && !ps2_overflow);
  assign ps2_clrn   = ~clr_q;
  assign key        = key_q;
  assign last_codes = last_q;

endmodule

// File: tb/tb_ps2_joypad_decoder.sv
// tb/tb_ps2_joypad_decoder.sv - Self-checking bench with FIFO model and key-set reference model.
module tb_ps2_joypad_decoder;

  logic        clk_4;
  logic        vb_rst;
  logic        ps2_ready;
  logic [7:0]  ps2_data;
  logic        ps2_overflow;
  logic        ps2_rdn;
  logic        ps2_clrn;
  logic        src_uart;
  logic        uart_rdy;
  logic [7:0]  uart_data;
  logic [7:0]  key;
  logic [15:0] last_codes;

  ps2_joypad_decoder dut (
    .clk_4        (clk_4),
    .vb_rst       (vb_rst),
    .ps2_ready    (ps2_ready),
    .ps2_data     (ps2_data),
    .ps2_overflow (ps2_overflow),
    .ps2_rdn      (ps2_rdn),
    .ps2_clrn     (ps2_clrn),
    .src_uart     (src_uart),
    .uart_rdy     (uart_rdy),
    .uart_data    (uart_data),
    .key          (key),
    .last_codes   (last_codes)
  );

  initial clk_4 = 1'b0;
  always #5 clk_4 = ~clk_4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo[$];
  int         cyc = 0;
  int         pop_cyc[$];
  int         clr_cnt = 0;

  // Reference model: set of held keys, keyed by {ext, code}.
  int          jp_bit[int];
  bit          pressed[int];
  bit          m_ext, m_brk;
  logic [15:0] m_last;

  typedef struct {
    int          n;
    logic [23:0] b;
    logic [7:0]  k;
    logic [15:0] lc;
  } vec_t;
  vec_t tbl[20];

  logic [7:0] pool[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fifo_outs();
    ps2_ready = (fifo.size() != 0);
    ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic tick();
    logic pop, clr;
    @(negedge clk_4);
    pop = ~ps2_rdn;
    clr = ~ps2_clrn;
    @(posedge clk_4);
    #1;
    cyc++;
    if (clr) begin
      clr_cnt++;
      fifo.delete();
      ps2_overflow = 1'b0;
    end else if (pop && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pop_cyc.push_back(cyc);
    end
    fifo_outs();
  endtask

  function automatic void model_reset();
    pressed.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_last = 16'h0000;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k = {m_ext, b};
      if (jp_bit.exists(k)) begin
        if (m_brk) pressed.delete(k);
        else pressed[k] = 1'b1;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    m_last = {m_last[7:0], b};
  endfunction

  function automatic logic [7:0] model_key();
    logic [7:0] v;
    v = 8'h00;
    foreach (pressed[k]) v[jp_bit[k]] = 1'b1;
    return v;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    model_byte(b);
    fifo_outs();
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (fifo.size() != 0 && cnt < 200) begin
      tick();
      cnt++;
    end
    if (fifo.size() != 0) check("drain_timeout", fifo.size(), 0);
    repeat (4) tick();
  endtask

  initial begin
    logic [7:0] b;
    int         n;

    jp_bit[12'h01D] = 6; jp_bit[12'h01B] = 7; jp_bit[12'h01C] = 5; jp_bit[12'h023] = 4;
    jp_bit[12'h05A] = 3; jp_bit[12'h029] = 2; jp_bit[12'h04C] = 1; jp_bit[12'h052] = 0;
    jp_bit[12'h175] = 6; jp_bit[12'h172] = 7; jp_bit[12'h16B] = 5; jp_bit[12'h174] = 4;
    model_reset();

    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h29, 8'h4C, 8'h52, 8'h75, 8'h72, 8'h6B,
             8'h74, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'h00, 8'hE1, 8'h14, 8'h77};

    tbl[0]  = '{1, 24'h1D0000, 8'h40, 16'h001D};
    tbl[1]  = '{2, 24'hF01D00, 8'h00, 16'hF01D};
    tbl[2]  = '{2, 24'hE07500, 8'h40, 16'hE075};
    tbl[3]  = '{1, 24'h1D0000, 8'h40, 16'h751D};
    tbl[4]  = '{3, 24'hE0F075, 8'h40, 16'hF075};
    tbl[5]  = '{2, 24'hF01D00, 8'h00, 16'hF01D};
    tbl[6]  = '{2, 24'hE01D00, 8'h00, 16'hE01D};
    tbl[7]  = '{1, 24'h5A0000, 8'h08, 16'h1D5A};
    tbl[8]  = '{2, 24'hF05A00, 8'h00, 16'hF05A};
    tbl[9]  = '{1, 24'hAA0000, 8'h00, 16'h5AAA};
    tbl[10] = '{3, 24'hF0AA1D, 8'h40, 16'hAA1D};
    tbl[11] = '{2, 24'hE07200, 8'hC0, 16'hE072};
    tbl[12] = '{1, 24'h1B0000, 8'hC0, 16'h721B};
    tbl[13] = '{3, 24'hE0F072, 8'hC0, 16'hF072};
    tbl[14] = '{2, 24'hF01B00, 8'h40, 16'hF01B};
    tbl[15] = '{2, 24'hF01D00, 8'h00, 16'hF01D};
    tbl[16] = '{2, 24'hE06B00, 8'h20, 16'hE06B};
    tbl[17] = '{1, 24'h230000, 8'h30, 16'h6B23};
    tbl[18] = '{3, 24'hE0F06B, 8'h10, 16'hF06B};
    tbl[19] = '{2, 24'hF02300, 8'h00, 16'hF023};

    vb_rst = 1'b1; ps2_overflow = 1'b0; src_uart = 1'b0; uart_rdy = 1'b0; uart_data = 8'h00;
    fifo_outs();
    repeat (2) tick();
    check("rst_key", key, 8'h00);
    check("rst_last", last_codes, 16'h0000);
    check("rst_rdn", ps2_rdn, 1'b1);
    check("rst_clrn", ps2_clrn, 1'b1);
    vb_rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        b = tbl[i].b[23 - 8*j -: 8];
        push(b);
      end
      drain();
      check($sformatf("tbl%0d_key", i), key, tbl[i].k);
      check($sformatf("tbl%0d_last", i), last_codes, tbl[i].lc);
    end

    push(8'h29);
    tick();
    check("lat_rdn_low", ps2_rdn, 1'b0);
    tick();
    check("lat_rdn_high", ps2_rdn, 1'b1);
    check("lat_last_hold", last_codes, 16'hF023);
    tick();
    check("lat_last_upd", last_codes, 16'h2329);
    check("lat_key_hold", key, 8'h00);
    tick();
    check("lat_key_upd", key, 8'h04);

    pop_cyc.delete();
    push(8'hF0); push(8'h29); push(8'h4C);
    drain();
    check("thr_pops", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("thr_gap0", pop_cyc[1] - pop_cyc[0], 3);
      check("thr_gap1", pop_cyc[2] - pop_cyc[1], 3);
    end
    check("thr_key", key, model_key());

    foreach (pool[i]) if (i < 8) push(pool[i]);
    drain();
    check("ovf_pre_key", key, 8'hFF);
    clr_cnt = 0;
    fifo.push_back(8'h1D);
    fifo_outs();
    ps2_overflow = 1'b1;
    tick();
    check("ovf_clrn_low", ps2_clrn, 1'b0);
    check("ovf_no_pop", ps2_rdn, 1'b1);
    tick();
    check("ovf_clrn_high", ps2_clrn, 1'b1);
    tick();
    check("ovf_key", key, 8'h00);
    check("ovf_last", last_codes, 16'h0000);
    repeat (4) tick();
    check("ovf_clr_pulses", clr_cnt, 1);
    check("ovf_fifo_empty", fifo.size(), 0);
    model_reset();

    push(8'h5A);
    drain();
    check("uart_pre_key", key, 8'h08);
    src_uart = 1'b1; uart_data = 8'hA5; uart_rdy = 1'b1;
    tick();
    check("uart_sel_now", key, 8'h00);
    repeat (2) tick();
    check("uart_edge3", key, 8'h00);
    tick();
    check("uart_edge4", key, 8'hA5);
    push(8'h29);
    drain();
    check("uart_hold", key, 8'hA5);
    uart_rdy = 1'b0;
    src_uart = 1'b0;
    tick();
    check("uart_back_ps2", key, model_key());
    check("uart_back_val", key, 8'h0C);

    fifo.push_back(8'h1B);
    fifo_outs();
    tick();
    check("rstr_in_read", ps2_rdn, 1'b0);
    vb_rst = 1'b1;
    #1;
    check("rstr_rdn_async", ps2_rdn, 1'b1);
    check("rstr_key", key, 8'h00);
    check("rstr_last", last_codes, 16'h0000);
    check("rstr_clrn", ps2_clrn, 1'b1);
    model_reset();
    model_byte(8'h1B);
    repeat (2) tick();
    check("rstr_not_popped", fifo.size(), 1);
    vb_rst = 1'b0;
    drain();
    check("rstr_reread_key", key, 8'h80);
    check("rstr_reread_last", last_codes, 16'h001B);

    for (int r = 0; r < 60; r++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 9) == 0) b = 8'($urandom);
        else b = pool[$urandom_range(0, 20)];
        push(b);
      end
      drain();
      check($sformatf("rnd%0d_key", r), key, model_key());
      check($sformatf("rnd%0d_last", r), last_codes, m_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_joypad_decoder.md
# ps2_joypad_decoder

Converts the PS/2 keyboard scancode stream into the 8-bit Game Boy joypad vector driven into `boy.key`. It sits directly between `ps2_keyboard` (scancode FIFO) and the core. It owns the FIFO read handshake, overflow recovery, F0/E0 prefix decoding and per-key held state. It also provides an alternate path that takes the joypad byte directly from the UART receiver.

## Interface
- No parameters. Scancode map constants live in the package.
- `clk_4` in 1: system clock, ~4 MHz.
- `vb_rst` in 1: asynchronous reset, active-high.
- `ps2_ready` in 1: FIFO not empty (`ps2_keyboard.ready`).
- `ps2_data` in 8: FIFO head byte, valid while `ps2_ready`=1.
- `ps2_overflow` in 1: FIFO overflow flag.
- `ps2_rdn` out 1: FIFO pop, active-low, one cycle.
- `ps2_clrn` out 1: FIFO clear, active-low, one cycle.
- `src_uart` in 1: 1 selects the UART source (SW[0]).
- `uart_rdy` in 1: UART byte ready, from the clkGlb domain, level.
- `uart_data` in 8: UART byte, stable while `uart_rdy`=1.
- `key` out 8: joypad vector, active-high. [7] down, [6] up, [5] left, [4] right, [3] start, [2] select, [1] A, [0] B.
- `last_codes` out 16: {previous byte, latest byte} popped from the FIFO, for the HEX display.

## Operation
- Read FSM has three states: IDLE, READ and GAP.
  - IDLE goes to READ when `ps2_ready`=1 and `ps2_overflow`=0.
  - In READ, `ps2_rdn`=0, `ps2_data` is captured, and the FSM goes to GAP.
  - GAP lasts one cycle (lets `ready` update), then the FSM goes to IDLE.
- Overflow has priority in any state. When `ps2_overflow`=1:
  - `ps2_clrn`=0 for exactly one cycle.
  - All held flags, prefixes and `last_codes` are cleared.
  - The FSM goes to GAP.
  - No pop happens that cycle.
- Prefix handling on a captured byte:
  - E0 sets `ext`.
  - F0 sets `brk`.
  - Any other byte is decoded with the current `ext`/`brk`, then both prefixes are cleared.
- Ignored bytes: AA, FA, FE, EE, 00 and FF. They clear both prefixes and change no flag.
- Any unmapped code (with or without E0, including the E1 pause sequence bytes) changes nothing except clearing the prefixes.
- There are 12 held flags. A make sets the flag; a break (brk=1) clears it.
  - Primary set (ext=0): W 1D→up, S 1B→down, A 1C→left, D 23→right, Enter 5A→start, Space 29→select, ; 4C→A, ' 52→B.
  - Arrow set (ext=1): 75→up, 72→down, 6B→left, 74→right.
  - A code with the wrong ext value does not match its entry.
- Each direction bit is the OR of its primary and arrow flags. Releasing one of the two keys does not clear the bit while the other is held.
- `last_codes` shifts on every captured byte, including prefixes.
- UART path: `uart_rdy` passes through a 2-flop synchronizer. On a rising edge of the synchronized signal with `src_uart`=1, `uart_data` is captured into `uart_key`.
- Output register: `key` = `uart_key` when `src_uart`=1, otherwise the PS/2 OR vector.
- While `src_uart`=1, the PS/2 FSM keeps draining the FIFO and updating its flags, so switching back to PS/2 shows the current PS/2 state.

## Timing
- Reset values:
  - `key`=00, `last_codes`=0000, `ps2_rdn`=1, `ps2_clrn`=1.
  - FSM in IDLE; all flags, prefixes, `uart_key` and the synchronizer are 0.
- `ps2_ready` sampled 1 in IDLE at edge N: `ps2_rdn`=0 during cycle N+1. Flags and `last_codes` update at edge N+2. `key` updates at edge N+3.
- Pop throughput: at most one byte per 3 cycles.
- Overflow seen at edge N: `ps2_clrn`=0 during cycle N+1. `key`=00 after edge N+2.
- UART: `key` updates 4 edges after `uart_rdy` rises (2 sync, 1 edge detect, 1 output).
- Changing `src_uart` takes effect at the next edge.
- `vb_rst` asserted mid-READ: `ps2_rdn` returns to 1 immediately (async). The in-flight byte is not captured.

## Structure
- Package `ps2_joypad_pkg` holds:
  - scancode localparams (primary and arrow codes, E0, F0, ignore list);
  - joypad bit indices;
  - FSM state enum.
- One natural sub-module is `sync_edge`: a 2-flop synchronizer plus rising-edge pulse, used for `uart_rdy`.

## Test plan
- After reset, feed bytes 1D then F0 1D through the FIFO model. Required: `key`=40 after the make, 00 after the break, `last_codes`=F01D.
- Feed E0 75 (key=40), then 1D (still 40), then E0 F0 75 (still 40), then F0 1D. Required: `key`=00 only after the last break.
- Feed E0 then 1D. Required: the arrow table has no 1D entry, so nothing is set and `key`=00. A following 5A gives `key`=08, confirming the prefix was cleared.
- Assert `ps2_overflow` while `key`=FF. Required: a single-cycle `ps2_clrn` pulse, then `key`=00 and `last_codes`=0000.
- Set `src_uart`=1 and raise `uart_rdy` with `uart_data`=A5. Required: `key`=A5 four edges later. Then clear `src_uart`: `key` returns to the PS/2 vector in one edge.
- Assert `vb_rst` during a READ cycle. Required: `ps2_rdn`=1 asynchronously and all outputs return to their reset values.
